alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one combinational ALU between two requesters (e.g. the execute stage
//   and an address/branch unit) using a round-robin arbiter.
//   Each operation is accepted with a valid/ready handshake and sent to the ALU
//   from registered operands. The result and flags are registered and returned on
//   a per-requester response channel, which is held until that requester accepts it.
// PARAMETERS
//   WIDTH  32  datapath width of operands/result; must match the ALU instance
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   reqN_valid   in   1      (N=0,1) requester N presents an operation
//   reqN_ready   out  1      (N=0,1) operation accepted this cycle when valid&ready
//   reqN_a       in   WIDTH  (N=0,1) operand a
//   reqN_b       in   WIDTH  (N=0,1) operand b
//   reqN_s       in   3      (N=0,1) ALU opcode (0 sub,1 add,2 and,3 or,4 xor,5 srl,6 sll,7 sra)
//   rspN_valid   out  1      (N=0,1) result for requester N available
//   rspN_ready   in   1      (N=0,1) requester N consumes result when valid&ready
//   rspN_y       out  WIDTH  (N=0,1) registered ALU result
//   rspN_f       out  3      (N=0,1) registered ALU flags
//   alu_a        out  WIDTH  to ALU operand a
//   alu_b        out  WIDTH  to ALU operand b
//   alu_s        out  3      to ALU opcode
//   alu_y        in   WIDTH  from ALU result
//   alu_f        in   3      from ALU flags
//   busy         out  1      high whenever state != IDLE
// BEHAVIOUR
//   FSM states: IDLE -> EXEC -> RESP -> IDLE. One operation is in flight at most.
//   IDLE:
//     - grant = requester whose valid is high; if both are high, the one not
//       granted last (last_grant register)
//     - reqN_ready = (state==IDLE) && grant==N, asserted combinationally
//     - ready is never high for both requesters in the same cycle
//     - on handshake: latch a/b/s into op regs, latch gnt_id, set last_grant=N, go EXEC
//   EXEC (exactly 1 cycle):
//     - ALU sees the op regs; at the end of the cycle capture alu_y/alu_f into the
//       result regs, then go RESP
//   RESP:
//     - rsp[gnt_id]_valid=1 and the other rsp_valid=0; y/f stay stable while waiting
//     - on rsp[gnt_id]_valid & rsp[gnt_id]_ready: go IDLE
//     - no new request is accepted in this same cycle
//   Latency: handshake in cycle T -> rsp_valid high in cycle T+2.
//     Best throughput is one op every 3 cycles.
//   alu_a/alu_b/alu_s = op regs at all times, not only in EXEC.
//   rspN_y/rspN_f are both driven from the shared result regs; they are meaningful
//     only while rspN_valid is high.
//   Ignored inputs: rspN_ready while rspN_valid is low; reqN_s/a/b while not handshaking.
//   Requesters may drop valid before ready; there is no penalty and no state change.
//   Reset values: state=IDLE, op regs=0, result regs=0, gnt_id=0, last_grant=1
//     (req0 wins the first tie). All ready/valid outputs and busy are 0.
//   Reset mid-operation (EXEC or RESP): the op is discarded, no response is
//     produced, and the FSM returns to IDLE next cycle.
//   No overflow handling here: flags are passed through exactly as the ALU produces them.
// TESTING (bench instantiates the team ALU, WIDTH=32)
//   1 req0 a=5,b=5,s=0 alone, rsp0_ready=1 -> req0_ready cycle T; rsp0_valid T+2,
//     y=0, f=3'b001; rsp1_valid never high.
//   2 req1 a=7,b=3,s=1, rsp1_ready=0 for 4 cycles -> rsp1_valid held with y=10,
//     f=3'b000 stable; busy=1; req0_ready stays 0 throughout.
//   3 req0 and req1 both valid continuously after reset, req0 a=1,b=2,s=3,
//     req1 a=8,b=1,s=6 -> grants alternate 0,1,0,1; y alternates 3,16.
//   4 req0 a=32'h8000_0000,b=4,s=7 -> y=32'hF800_0000; same operands with s=5
//     -> y=32'h0800_0000.
//   5 assert rst for 1 cycle during EXEC, then during RESP -> no rsp_valid,
//     busy=0 next cycle; the next req0 is granted first.
//   6 req0_valid pulsed 1 cycle while FSM is in RESP -> not accepted; no extra response.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Operands and results are registered; one operation is in flight at a time.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_s,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_s,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_y,
    output logic [2:0]       rsp0_f,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_y,
    output logic [2:0]       rsp1_f,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_s,
    input  logic [WIDTH-1:0] alu_y,
    input  logic [2:0]       alu_f,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [2:0]       op_s_q, op_s_d;
    logic [WIDTH-1:0] res_y_q, res_y_d;
    logic [2:0]       res_f_q, res_f_d;
    logic             gnt_id_q, gnt_id_d;
    logic             last_grant_q, last_grant_d;

    logic grant;
    logic req_fire;
    logic rsp_fire;

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
    end

    // Handshake outputs are held low while reset is asserted, even mid-operation.
    assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = !rst && (state_q == IDLE) && req1_valid &&  grant;
    assign rsp0_valid = !rst && (state_q == RESP) && !gnt_id_q;
    assign rsp1_valid = !rst && (state_q == RESP) &&  gnt_id_q;

    assign req_fire = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign rsp_fire = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign alu_a  = op_a_q;
    assign alu_b  = op_b_q;
    assign alu_s  = op_s_q;
    assign rsp0_y = res_y_q;
    assign rsp0_f = res_f_q;
    assign rsp1_y = res_y_q;
    assign rsp1_f = res_f_q;
    assign busy   = (state_q != IDLE);

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_s_d       = op_s_q;
        res_y_d      = res_y_q;
        res_f_d      = res_f_q;
        gnt_id_d     = gnt_id_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    op_a_d       = grant ? req1_a : req0_a;
                    op_b_d       = grant ? req1_b : req0_b;
                    op_s_d       = grant ? req1_s : req0_s;
                    gnt_id_d     = grant;
                    last_grant_d = grant;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                res_y_d = alu_y;
                res_f_d = alu_f;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_s_q       <= '0;
            res_y_q      <= '0;
            res_f_q      <= '0;
            gnt_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_s_q       <= op_s_d;
            res_y_q      <= res_y_d;
            res_f_q      <= res_f_d;
            gnt_id_q     <= gnt_id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU attached.
// ALU flags are {negative, signed overflow, zero}.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_s, req1_s;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] rsp0_y, rsp1_y;
    logic [2:0]       rsp0_f, rsp1_f;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [2:0]       alu_s, alu_f;
    logic             busy;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] y;
        logic [2:0]       f;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_y(rsp0_y), .rsp0_f(rsp0_f),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_y(rsp1_y), .rsp1_f(rsp1_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_y(alu_y), .alu_f(alu_f),
        .busy(busy)
    );

    // Behavioural stand-in for the team ALU.
    always_comb begin
        logic ovf;
        alu_y = '0;
        ovf   = 1'b0;
        case (alu_s)
            3'd0: begin
                alu_y = alu_a - alu_b;
                ovf   = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
            end
            3'd1: begin
                alu_y = alu_a + alu_b;
                ovf   = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
            end
            3'd2: alu_y = alu_a & alu_b;
            3'd3: alu_y = alu_a | alu_b;
            3'd4: alu_y = alu_a ^ alu_b;
            3'd5: alu_y = alu_a >> alu_b[4:0];
            3'd6: alu_y = alu_a << alu_b[4:0];
            default: alu_y = $signed(alu_a) >>> alu_b[4:0];
        endcase
        alu_f = {alu_y[31], ovf, (alu_y == '0)};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input logic id, input logic [WIDTH-1:0] y, input logic [2:0] f);
        exp_t e;
        check("rsp_pending", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_id", id, e.id);
            check("rsp_y", y, e.y);
            check("rsp_f", f, e.f);
        end
    endtask

    // Monitor: compares every accepted response against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp0_valid || rsp1_valid) check("rsp_onehot", rsp0_valid && rsp1_valid, 0);
            if (req0_ready || req1_ready) check("ready_onehot", req0_ready && req1_ready, 0);
            if (rsp0_valid && rsp0_ready) pop_check(1'b0, rsp0_y, rsp0_f);
            if (rsp1_valid && rsp1_ready) pop_check(1'b1, rsp1_y, rsp1_f);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the handshake edge.
    task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] s, input logic [31:0] ey, input logic [2:0] ef,
                        input logic push);
        logic done;
        exp_t e;
        done = 1'b0;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_s = s;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_s = s;
        end
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
                done = 1'b1;
                if (push) begin
                    e.id = id; e.y = ey; e.f = ef;
                    sb.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        check("send_handshake", done, 1);
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    initial begin
        int   grants;
        logic order [4];
        exp_t e;

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_s = 0;
        req1_a = 0; req1_b = 0; req1_s = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_rsp0_valid", rsp0_valid, 0);
        check("reset_rsp1_valid", rsp1_valid, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        check("reset_alu_s", alu_s, 0);
        check("reset_rsp_y", rsp0_y, 0);
        @(posedge clk); #1;

        // 1: single req0 subtract, latency T -> T+2
        send(0, 5, 5, 3'd0, 32'd0, 3'b001, 1);
        @(negedge clk);
        check("t1_exec_rsp0_valid", rsp0_valid, 0);
        check("t1_exec_busy", busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_resp_rsp0_valid", rsp0_valid, 1);
        @(posedge clk); #1;

        // 2: req1 add with response back-pressure; req0 waiting must not be accepted
        rsp1_ready = 0;
        send(1, 7, 3, 3'd1, 32'd10, 3'b000, 1);
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 32'd99; req0_b = 32'd1; req0_s = 3'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_rsp1_valid", rsp1_valid, 1);
            check("t2_rsp1_y", rsp1_y, 32'd10);
            check("t2_rsp1_f", rsp1_f, 3'b000);
            check("t2_busy", busy, 1);
            check("t2_req0_ready", req0_ready, 0);
            @(posedge clk); #1;
        end
        req0_valid = 0;
        rsp1_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_idle_after", busy, 0);
        @(posedge clk); #1;

        // 3: both requesters valid continuously after reset -> 0,1,0,1
        do_reset();
        req0_valid = 1; req0_a = 1; req0_b = 2; req0_s = 3'd3;
        req1_valid = 1; req1_a = 8; req1_b = 1; req1_s = 3'd6;
        grants = 0;
        for (int n = 0; n < 40 && grants < 4; n++) begin
            @(negedge clk);
            if (req0_ready) begin
                order[grants] = 1'b0;
                e.id = 0; e.y = 32'd3; e.f = 3'b000;
                sb.push_back(e);
                grants++;
            end else if (req1_ready) begin
                order[grants] = 1'b1;
                e.id = 1; e.y = 32'd16; e.f = 3'b000;
                sb.push_back(e);
                grants++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        check("t3_grant_count", grants, 4);
        check("t3_grant0", order[0], 0);
        check("t3_grant1", order[1], 1);
        check("t3_grant2", order[2], 0);
        check("t3_grant3", order[3], 1);
        repeat (4) begin @(posedge clk); #1; end

        // 4: shifts of a negative operand
        send(0, 32'h8000_0000, 4, 3'd7, 32'hF800_0000, 3'b100, 1);
        send(0, 32'h8000_0000, 4, 3'd5, 32'h0800_0000, 3'b000, 1);
        repeat (3) begin @(posedge clk); #1; end

        // 5: reset during EXEC, then during RESP
        send(0, 9, 9, 3'd1, 32'd18, 3'b000, 0);
        rst = 1;
        @(negedge clk);
        check("t5_exec_rst_rsp0", rsp0_valid, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("t5_exec_rst_busy", busy, 0);
        check("t5_exec_rst_rsp0_after", rsp0_valid, 0);
        @(posedge clk); #1;
        send(0, 9, 9, 3'd1, 32'd18, 3'b000, 0);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("t5_resp_rst_rsp0", rsp0_valid, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("t5_resp_rst_busy", busy, 0);
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 1; req0_b = 1; req0_s = 3'd1;
        req1_valid = 1; req1_a = 2; req1_b = 2; req1_s = 3'd1;
        @(negedge clk);
        check("t5_first_grant_req0", req0_ready, 1);
        check("t5_first_grant_req1", req1_ready, 0);
        if (req0_ready) begin
            e.id = 0; e.y = 32'd2; e.f = 3'b000;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        repeat (4) begin @(posedge clk); #1; end

        // 6: req0 pulse during RESP is ignored
        rsp0_ready = 0;
        send(0, 2, 3, 3'd1, 32'd5, 3'b000, 1);
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 32'd100; req0_b = 32'd100; req0_s = 3'd1;
        @(negedge clk);
        check("t6_req0_ready_in_resp", req0_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0;
        rsp0_ready = 1;
        repeat (6) begin @(posedge clk); #1; end
        check("t6_busy", busy, 0);

        for (int n = 0; n < 50 && sb.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        check("final_scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
